// File: rtl/commute_stage_if.sv
// Per-round sample bus of the commute stage: the round inputs plus the valid/ready handshake.
interface commute_stage_if #(
    parameter int SPEED_W = 7,
    parameter int RAND_W  = 7
) ();
    logic               in_valid;
    logic               in_ready;
    logic [SPEED_W-1:0] speed;
    logic [RAND_W-1:0]  random;
    logic [1:0]         breakfast;
    logic [1:0]         movement;
    logic               weather;

    modport master (
        output in_valid, speed, random, breakfast, movement, weather,
        input  in_ready
    );

    modport slave (
        input  in_valid, speed, random, breakfast, movement, weather,
        output in_ready
    );
endinterface

// File: rtl/commute_stage_seq.sv
// Multi-round commute-stage evaluator: applies speed/weather/random-fault rules per accepted
// sample, accumulates a saturating bonus score, counts strikes and reports a final pass/fail.
module commute_stage_seq #(
    parameter int SPEED_W     = 7,
    parameter int RAND_W      = 7,
    parameter int ROUNDS      = 4,
    parameter int MAX_STRIKES = 2,
    parameter int SCORE_W     = 5,
    parameter int LB_CLEAR    = 20,
    parameter int UB_CLEAR    = 50,
    parameter int LB_RAIN     = 30,
    parameter int UB_RAIN     = 70
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    commute_stage_if.slave                     sbus,
    output logic                               round_done,
    output logic                               round_fault,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic [SCORE_W-1:0]                 score,
    output logic [$clog2(MAX_STRIKES+1)-1:0]   strikes,
    output logic [$clog2(ROUNDS+1)-1:0]        rounds_played
);
    localparam int STRIKE_W = $clog2(MAX_STRIKES + 1);
    localparam int ROUND_W  = $clog2(ROUNDS + 1);

    localparam logic [SPEED_W-1:0] LO_CLEAR = SPEED_W'(LB_CLEAR);
    localparam logic [SPEED_W-1:0] HI_CLEAR = SPEED_W'(UB_CLEAR);
    localparam logic [SPEED_W-1:0] LO_RAIN  = SPEED_W'(LB_RAIN);
    localparam logic [SPEED_W-1:0] HI_RAIN  = SPEED_W'(UB_RAIN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [1:0] bonus_f(
        input logic [1:0] bf,
        input logic [1:0] mv,
        input logic       slow,
        input logic       r3,
        input logic       r5
    );
        logic [1:0] b;
        case (bf)
            2'b00:   b = 2'b00;
            2'b01:   b = {1'b0, |mv};
            2'b10:   b = slow ? 2'b00 : {mv[1], 1'b0};
            2'b11:   b = (mv == {r3, r5}) ? 2'b11 : 2'b00;
            default: b = 2'b00;
        endcase
        return b;
    endfunction

    // Zero-extended add that clamps at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add_f(
        input logic [SCORE_W-1:0] s,
        input logic [1:0]         b
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + (SCORE_W+1)'(b);
        if (sum[SCORE_W]) begin
            return {SCORE_W{1'b1}};
        end else begin
            return sum[SCORE_W-1:0];
        end
    endfunction

    state_t              state_r;
    logic                in_ready_r;
    logic                busy_r;
    logic                round_done_r;
    logic                round_fault_r;
    logic                done_r;
    logic                pass_r;
    logic [SCORE_W-1:0]  score_r;
    logic [STRIKE_W-1:0] strikes_r;
    logic [ROUND_W-1:0]  rounds_r;

    logic [SPEED_W-1:0]  lo_s;
    logic [SPEED_W-1:0]  hi_s;
    logic                over_s;
    logic                slow_s;
    logic                crash_s;
    logic                late_s;
    logic                nopark_s;
    logic                fault_s;
    logic [1:0]          bonus_s;
    logic [SCORE_W-1:0]  score_nx_s;
    logic [STRIKE_W-1:0] strikes_nx_s;
    logic [ROUND_W-1:0]  rounds_nx_s;
    logic                strike_lim_s;
    logic                round_lim_s;
    logic                accept_s;
    logic                unused_rand_s;

    assign unused_rand_s = ^sbus.random;

    // Per-round rule evaluation and next counter values for the sample on the bus.
    always_comb begin
        lo_s         = sbus.weather ? LO_RAIN : LO_CLEAR;
        hi_s         = sbus.weather ? HI_RAIN : HI_CLEAR;
        over_s       = (sbus.speed > hi_s);
        slow_s       = (sbus.speed < lo_s);
        crash_s      = over_s & (sbus.random[0] | sbus.random[1]);
        late_s       = slow_s & (sbus.random[2] ^ sbus.random[3]);
        nopark_s     = sbus.random[4] & sbus.random[2] & sbus.random[0];
        fault_s      = crash_s | late_s | nopark_s;
        bonus_s      = bonus_f(sbus.breakfast, sbus.movement, slow_s,
                               sbus.random[3], sbus.random[5]);
        if (fault_s) begin
            score_nx_s = score_r;
        end else begin
            score_nx_s = sat_add_f(score_r, bonus_s);
        end
        strikes_nx_s = strikes_r + STRIKE_W'(late_s | nopark_s);
        rounds_nx_s  = rounds_r + ROUND_W'(1'b1);
        strike_lim_s = (strikes_nx_s == STRIKE_W'(MAX_STRIKES));
        round_lim_s  = (rounds_nx_s == ROUND_W'(ROUNDS));
        accept_s     = sbus.in_valid & in_ready_r;
    end

    // Game FSM with all outputs registered; done and round_done are single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            in_ready_r    <= 1'b0;
            busy_r        <= 1'b0;
            round_done_r  <= 1'b0;
            round_fault_r <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            score_r       <= {SCORE_W{1'b0}};
            strikes_r     <= {STRIKE_W{1'b0}};
            rounds_r      <= {ROUND_W{1'b0}};
        end else begin
            round_done_r <= 1'b0;
            done_r       <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_r       <= S_RUN;
                        in_ready_r    <= 1'b1;
                        busy_r        <= 1'b1;
                        round_fault_r <= 1'b0;
                        pass_r        <= 1'b0;
                        score_r       <= {SCORE_W{1'b0}};
                        strikes_r     <= {STRIKE_W{1'b0}};
                        rounds_r      <= {ROUND_W{1'b0}};
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_RUN: begin
                    if (accept_s) begin
                        round_done_r  <= 1'b1;
                        round_fault_r <= fault_s;
                        score_r       <= score_nx_s;
                        strikes_r     <= strikes_nx_s;
                        rounds_r      <= rounds_nx_s;
                        if (crash_s || strike_lim_s || round_lim_s) begin
                            state_r    <= S_DONE;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            pass_r     <= ~(crash_s | strike_lim_s);
                        end else begin
                            state_r <= S_RUN;
                        end
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign sbus.in_ready  = in_ready_r;
    assign busy           = busy_r;
    assign round_done     = round_done_r;
    assign round_fault    = round_fault_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign score          = score_r;
    assign strikes        = strikes_r;
    assign rounds_played  = rounds_r;
endmodule

// File: tb/tb_commute_stage_seq.sv
// Directed bench for commute_stage_seq; a second instance with a 3-bit score shares the stimulus.
module tb_commute_stage_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [6:0] speed = 7'd0;
    logic [6:0] random = 7'd0;
    logic [1:0] breakfast = 2'd0;
    logic [1:0] movement = 2'd0;
    logic       weather = 1'b0;

    int errors = 0;
    int checks = 0;

    logic       round_done, round_fault, busy, done, pass;
    logic [4:0] score;
    logic [1:0] strikes;
    logic [2:0] rounds_played;
    logic       round_done3, round_fault3, busy3, done3, pass3;
    logic [2:0] score3;
    logic [1:0] strikes3;
    logic [2:0] rounds_played3;

    commute_stage_if #(.SPEED_W(7), .RAND_W(7)) bus ();
    commute_stage_if #(.SPEED_W(7), .RAND_W(7)) bus3 ();

    assign bus.in_valid   = in_valid;
    assign bus.speed      = speed;
    assign bus.random     = random;
    assign bus.breakfast  = breakfast;
    assign bus.movement   = movement;
    assign bus.weather    = weather;
    assign bus3.in_valid  = in_valid;
    assign bus3.speed     = speed;
    assign bus3.random    = random;
    assign bus3.breakfast = breakfast;
    assign bus3.movement  = movement;
    assign bus3.weather   = weather;

    commute_stage_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sbus(bus),
        .round_done(round_done), .round_fault(round_fault), .busy(busy), .done(done),
        .pass(pass), .score(score), .strikes(strikes), .rounds_played(rounds_played)
    );

    commute_stage_seq #(.SCORE_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .sbus(bus3),
        .round_done(round_done3), .round_fault(round_fault3), .busy(busy3), .done(done3),
        .pass(pass3), .score(score3), .strikes(strikes3), .rounds_played(rounds_played3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sample(input logic [6:0] sp, input logic [6:0] rn,
                              input logic [1:0] bf, input logic [1:0] mv, input logic w);
        speed = sp; random = rn; breakfast = bf; movement = mv; weather = w;
    endtask

    task automatic new_game();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic one_round();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if ({busy, done, pass, round_done, round_fault} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, pass, round_done, round_fault}); end
        checks++; if ({score, strikes, rounds_played} !== 10'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", score, strikes, rounds_played); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        new_game();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL start_in_ready: got %b expected 1", bus.in_ready); end
        set_sample(7'd35, 7'd0, 2'b01, 2'b10, 1'b0);
        one_round();
        checks++; if (rounds_played !== 3'd1) begin errors++; $display("FAIL pre_reset_rounds: got %0d expected 1", rounds_played); end
        // Assert reset between edges to exercise the asynchronous path.
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, bus.in_ready, round_done, score, rounds_played} !== 11'd0) begin errors++; $display("FAIL midrun_reset: got %b expected all zero", {busy, bus.in_ready, round_done, score, rounds_played}); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrun_reset_done: got %b expected 0", done); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 0", bus.in_ready); end
        new_game();
        checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL restart_in_ready: got %b%b expected 11", bus.in_ready, busy); end
    endtask

    // Continues the game opened by test_reset, with in_valid held high for back-to-back accepts.
    task automatic test_back_to_back();
        set_sample(7'd35, 7'd0, 2'b01, 2'b10, 1'b0);
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (round_done !== 1'b1 || round_fault !== 1'b0) begin errors++; $display("FAIL clean_round%0d_flags: got %b%b expected 10", i, round_done, round_fault); end
            checks++; if (score !== 5'(i) || rounds_played !== 3'(i)) begin errors++; $display("FAIL clean_round%0d_count: got score %0d rounds %0d expected %0d", i, score, rounds_played, i); end
            checks++; if (done !== (i == 4)) begin errors++; $display("FAIL clean_round%0d_done: got %b expected %b", i, done, (i == 4)); end
        end
        in_valid = 1'b0;
        checks++; if (pass !== 1'b1 || strikes !== 2'd0) begin errors++; $display("FAIL clean_result: got pass %b strikes %0d expected 1/0", pass, strikes); end
        checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clean_idle: got %b%b expected 00", bus.in_ready, busy); end
        tick();
        checks++; if (done !== 1'b0 || round_done !== 1'b0) begin errors++; $display("FAIL clean_pulse: got %b%b expected 00", done, round_done); end
        checks++; if (pass !== 1'b1 || score !== 5'd4) begin errors++; $display("FAIL clean_hold: got pass %b score %0d expected 1/4", pass, score); end
    endtask

    task automatic test_rain_crash();
        new_game();
        checks++; if (score !== 5'd0 || rounds_played !== 3'd0 || pass !== 1'b0) begin errors++; $display("FAIL rain_clear: got %0d/%0d/%b expected 0/0/0", score, rounds_played, pass); end
        set_sample(7'd70, 7'b0000001, 2'b01, 2'b10, 1'b1);
        one_round();
        checks++; if (round_fault !== 1'b0 || score !== 5'd1 || done !== 1'b0) begin errors++; $display("FAIL rain_edge70: got fault %b score %0d done %b expected 0/1/0", round_fault, score, done); end
        speed = 7'd71;
        one_round();
        checks++; if (round_fault !== 1'b1 || done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL rain_crash: got fault %b done %b pass %b expected 1/1/0", round_fault, done, pass); end
        checks++; if (rounds_played !== 3'd2 || score !== 5'd1 || strikes !== 2'd0) begin errors++; $display("FAIL rain_crash_counts: got %0d/%0d/%0d expected 2/1/0", rounds_played, score, strikes); end
    endtask

    task automatic test_strike_limit();
        new_game();
        set_sample(7'd10, 7'b0000100, 2'b01, 2'b11, 1'b0);
        one_round();
        checks++; if (round_fault !== 1'b1 || strikes !== 2'd1 || done !== 1'b0 || score !== 5'd0) begin errors++; $display("FAIL strike1: got %b/%0d/%b/%0d expected 1/1/0/0", round_fault, strikes, done, score); end
        one_round();
        checks++; if (strikes !== 2'd2 || done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL strike2: got strikes %0d done %b pass %b expected 2/1/0", strikes, done, pass); end
        checks++; if (rounds_played !== 3'd2 || score !== 5'd0) begin errors++; $display("FAIL strike2_counts: got %0d/%0d expected 2/0", rounds_played, score); end
    endtask

    // Clear-weather range edges, nopark, and strike limit winning over the round limit.
    task automatic test_boundary();
        new_game();
        set_sample(7'd20, 7'b0000100, 2'b10, 2'b10, 1'b0);
        one_round();
        checks++; if (round_fault !== 1'b0 || score !== 5'd2) begin errors++; $display("FAIL bound_lo20: got fault %b score %0d expected 0/2", round_fault, score); end
        set_sample(7'd50, 7'b0000001, 2'b10, 2'b10, 1'b0);
        one_round();
        checks++; if (round_fault !== 1'b0 || score !== 5'd4) begin errors++; $display("FAIL bound_hi50: got fault %b score %0d expected 0/4", round_fault, score); end
        set_sample(7'd19, 7'b0000100, 2'b10, 2'b10, 1'b0);
        one_round();
        checks++; if (round_fault !== 1'b1 || strikes !== 2'd1 || score !== 5'd4) begin errors++; $display("FAIL bound_slow19: got %b/%0d/%0d expected 1/1/4", round_fault, strikes, score); end
        set_sample(7'd35, 7'b0010101, 2'b10, 2'b10, 1'b0);
        one_round();
        checks++; if (round_fault !== 1'b1 || strikes !== 2'd2 || rounds_played !== 3'd4) begin errors++; $display("FAIL bound_nopark: got %b/%0d/%0d expected 1/2/4", round_fault, strikes, rounds_played); end
        checks++; if (done !== 1'b1 || pass !== 1'b0 || score !== 5'd4) begin errors++; $display("FAIL bound_priority: got done %b pass %b score %0d expected 1/0/4", done, pass, score); end
    endtask

    task automatic test_saturation();
        logic [2:0] exp3 [4];
        exp3 = '{3'd3, 3'd6, 3'd7, 3'd7};
        new_game();
        set_sample(7'd35, 7'b0101000, 2'b11, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) begin
            one_round();
            checks++; if (score3 !== exp3[i] || round_fault3 !== 1'b0) begin errors++; $display("FAIL sat3_round%0d: got score %0d fault %b expected %0d/0", i + 1, score3, round_fault3, exp3[i]); end
            checks++; if (score !== 5'(3 * (i + 1))) begin errors++; $display("FAIL sat5_round%0d: got %0d expected %0d", i + 1, score, 3 * (i + 1)); end
        end
        checks++; if (pass3 !== 1'b1 || done3 !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL sat_result: got %b%b%b expected 111", pass3, done3, pass); end
    endtask

    task automatic test_handshake();
        new_game();
        set_sample(7'd35, 7'd0, 2'b01, 2'b10, 1'b0);
        one_round();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (rounds_played !== 3'd1 || round_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL idle_valid%0d: got %0d/%b/%b expected 1/0/1", i, rounds_played, round_done, busy); end
        end
        new_game();
        checks++; if (rounds_played !== 3'd1 || score !== 5'd1 || busy !== 1'b1) begin errors++; $display("FAIL start_in_run: got %0d/%0d/%b expected 1/1/1", rounds_played, score, busy); end
        for (int i = 0; i < 3; i++) one_round();
        checks++; if (done !== 1'b1 || pass !== 1'b1 || score !== 5'd4) begin errors++; $display("FAIL hs_finish: got %b/%b/%0d expected 1/1/4", done, pass, score); end
        new_game();
        checks++; if (score !== 5'd0 || rounds_played !== 3'd0 || pass !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL restart_clear: got %0d/%0d/%b/%b expected 0/0/0/1", score, rounds_played, pass, bus.in_ready); end
        one_round();
        checks++; if (score !== 5'd1 || rounds_played !== 3'd1 || round_done !== 1'b1) begin errors++; $display("FAIL restart_round: got %0d/%0d/%b expected 1/1/1", score, rounds_played, round_done); end
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_back_to_back();
        test_rain_crash();
        test_strike_limit();
        test_boundary();
        test_saturation();
        test_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
